// File: rtl/rf_pkg.sv
// Shared types and defaults for the parametrised register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_pkg;

  // Clear-engine state encoding
  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int RF_DEF_WIDTH = 4;
  localparam int RF_DEF_DEPTH = 4;

endpackage

// File: rtl/reg_file_param_if.sv
// Bus bundle between the ALU datapath and the register file.
// Latency: wires only.
// Backpressure: none on reads; writes during a clear are dropped and flagged via wr_drop.
interface reg_file_param_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] data_in;
  logic [AW-1:0]    wr;
  logic             write_enable;
  logic [AW-1:0]    rd1;
  logic [AW-1:0]    rd2;
  logic             clear_req;
  logic [WIDTH-1:0] data_out1;
  logic [WIDTH-1:0] data_out2;
  logic             valid_out1;
  logic             valid_out2;
  logic             busy;
  logic             wr_drop;

  modport master (
    output data_in, wr, write_enable, rd1, rd2, clear_req,
    input  data_out1, data_out2, valid_out1, valid_out2, busy, wr_drop
  );

  modport slave (
    input  data_in, wr, write_enable, rd1, rd2, clear_req,
    output data_out1, data_out2, valid_out1, valid_out2, busy, wr_drop
  );
endinterface

// File: rtl/rf_read_port.sv
// One asynchronous read port: DEPTH:1 data/valid mux with optional write forwarding.
// Latency: combinational.
// Backpressure: none.
module rf_read_port #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter bit BYPASS = 1'b1
) (
  input  logic [WIDTH-1:0]         mem_i [DEPTH],
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
  input  logic                     byp_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     valid_o
);
  logic hit;

  // Forward only a write that will actually be accepted at the coming edge
  assign hit = BYPASS && byp_en_i && (wr_addr_i == rd_addr_i);

  // Select forwarded data or the stored entry
  always_comb begin
    data_o  = mem_i[rd_addr_i];
    valid_o = valid_i[rd_addr_i];
    if (hit) begin
      data_o  = wr_data_i;
      valid_o = 1'b1;
    end
  end
endmodule

// File: rtl/reg_file_param.sv
// Parametrised register file: one write port, two async read ports, valid bits, bulk-clear engine.
// Latency: reads combinational (0-cycle write forwarding when BYPASS=1), writes land at the edge.
// Backpressure: while busy (clearing) writes are rejected and wr_drop pulses the next cycle.
module reg_file_param
  import rf_pkg::*;
#(
  parameter int WIDTH  = RF_DEF_WIDTH,
  parameter int DEPTH  = RF_DEF_DEPTH,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  reg_file_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  rf_state_e        state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic             wr_drop_q, wr_drop_d;
  logic             busy;
  logic             clr_en;
  logic             wr_acc;

  // busy comes straight from the state flop, so it is a registered output
  assign busy      = (state_q == RF_CLEAR);
  assign wr_acc    = bus.write_enable & ~busy;
  assign wr_drop_d = bus.write_enable & busy;

  // Clear engine: walk ptr from 0 to DEPTH-1, one entry per cycle; requests while clearing are ignored
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_en  = 1'b0;
    case (state_q)
      RF_IDLE: begin
        if (bus.clear_req) begin
          state_d = RF_CLEAR;
          ptr_d   = '0;
        end
      end
      RF_CLEAR: begin
        clr_en = 1'b1;
        ptr_d  = ptr_q + AW'(1);
        if (ptr_q == AW'(DEPTH - 1)) begin
          state_d = RF_IDLE;
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  // Control registers: FSM state, clear pointer, drop flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RF_IDLE;
      ptr_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Storage: clear and accepted write are mutually exclusive because writes are gated by busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= '0;
    end else if (clr_en) begin
      mem_q[ptr_q]   <= '0;
      valid_q[ptr_q] <= 1'b0;
    end else if (wr_acc) begin
      mem_q[bus.wr]   <= bus.data_in;
      valid_q[bus.wr] <= 1'b1;
    end
  end

  rf_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(BYPASS)) u_rp1 (
    .mem_i     (mem_q),
    .valid_i   (valid_q),
    .rd_addr_i (bus.rd1),
    .byp_en_i  (wr_acc),
    .wr_addr_i (bus.wr),
    .wr_data_i (bus.data_in),
    .data_o    (bus.data_out1),
    .valid_o   (bus.valid_out1)
  );

  rf_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(BYPASS)) u_rp2 (
    .mem_i     (mem_q),
    .valid_i   (valid_q),
    .rd_addr_i (bus.rd2),
    .byp_en_i  (wr_acc),
    .wr_addr_i (bus.wr),
    .wr_data_i (bus.data_in),
    .data_o    (bus.data_out2),
    .valid_o   (bus.valid_out2)
  );

  assign bus.busy    = busy;
  assign bus.wr_drop = wr_drop_q;
endmodule

// File: tb/tb_reg_file_param.sv
// Bench for reg_file_param: two instances (BYPASS=1 and BYPASS=0) share stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_reg_file_param;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AW = 3;
  localparam int OW = 2 * W + 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [W-1:0]  din;
  logic [AW-1:0] wr, rd1, rd2;
  logic          we, clr;

  reg_file_param_if #(.WIDTH(W), .DEPTH(D)) b_if ();
  reg_file_param_if #(.WIDTH(W), .DEPTH(D)) n_if ();

  assign b_if.data_in = din;  assign n_if.data_in = din;
  assign b_if.wr = wr;        assign n_if.wr = wr;
  assign b_if.write_enable = we; assign n_if.write_enable = we;
  assign b_if.rd1 = rd1;      assign n_if.rd1 = rd1;
  assign b_if.rd2 = rd2;      assign n_if.rd2 = rd2;
  assign b_if.clear_req = clr; assign n_if.clear_req = clr;

  reg_file_param #(.WIDTH(W), .DEPTH(D), .BYPASS(1'b1)) dut_b (.clk(clk), .reset(reset), .bus(b_if));
  reg_file_param #(.WIDTH(W), .DEPTH(D), .BYPASS(1'b0)) dut_n (.clk(clk), .reset(reset), .bus(n_if));

  // Observed outputs packed as {dout1, dout2, vld1, vld2, busy, wr_drop}
  logic [OW-1:0] obs_b, obs_n;
  assign obs_b = {b_if.data_out1, b_if.data_out2, b_if.valid_out1, b_if.valid_out2, b_if.busy, b_if.wr_drop};
  assign obs_n = {n_if.data_out1, n_if.data_out2, n_if.valid_out1, n_if.valid_out2, n_if.busy, n_if.wr_drop};

  // Reference model: contents, valid flags, clear progress and drop flag
  logic [W-1:0] m_mem [D];
  bit           m_val [D];
  bit           m_busy;
  int           m_clr_idx;
  bit           m_drop;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void model_reset();
    for (int i = 0; i < D; i++) begin
      m_mem[i] = '0;
      m_val[i] = 1'b0;
    end
    m_busy = 1'b0; m_clr_idx = 0; m_drop = 1'b0;
  endfunction

  // One rising edge of behaviour, using the inputs present at that edge
  function automatic void model_step();
    if (m_busy) begin
      m_drop = we;
      m_mem[m_clr_idx] = '0;
      m_val[m_clr_idx] = 1'b0;
      m_clr_idx++;
      if (m_clr_idx == D) begin
        m_busy = 1'b0;
        m_clr_idx = 0;
      end
    end else begin
      m_drop = 1'b0;
      if (we) begin
        m_mem[wr] = din;
        m_val[wr] = 1'b1;
      end
      if (clr) begin
        m_busy = 1'b1;
        m_clr_idx = 0;
      end
    end
  endfunction

  function automatic logic [OW-1:0] exp_vec(bit byp);
    logic [W-1:0] d1, d2;
    bit v1, v2, fwd;
    fwd = byp && we && !m_busy;
    d1 = m_mem[rd1]; v1 = m_val[rd1];
    d2 = m_mem[rd2]; v2 = m_val[rd2];
    if (fwd && wr == rd1) begin d1 = din; v1 = 1'b1; end
    if (fwd && wr == rd2) begin d2 = din; v2 = 1'b1; end
    return {d1, d2, v1, v2, m_busy, m_drop};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    #1;
  endtask

  task automatic fill_all();
    for (int a = 0; a < D; a++) begin
      we = 1'b1; wr = AW'(a); din = W'($urandom);
      tick();
    end
    we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; we = 1'b0; clr = 1'b0; din = '0; wr = '0; rd1 = '0; rd2 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int a = 0; a < D; a++) begin
      rd1 = AW'(a); rd2 = AW'(D - 1 - a);
      #1;
      n_checks++;
      if (obs_b !== '0) begin n_errors++; $display("FAIL reset_b addr %0d got %h exp 0", a, obs_b); end
      n_checks++;
      if (obs_n !== '0) begin n_errors++; $display("FAIL reset_n addr %0d got %h exp 0", a, obs_n); end
    end
    fill_all();
    rd1 = 3'd3; rd2 = 3'd6;
    #1;
    n_checks++;
    if (obs_b !== exp_vec(1'b1)) begin n_errors++; $display("FAIL prefill got %h exp %h", obs_b, exp_vec(1'b1)); end
    #2 reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (obs_b !== '0) begin n_errors++; $display("FAIL async_reset_b got %h exp 0", obs_b); end
    n_checks++;
    if (obs_n !== '0) begin n_errors++; $display("FAIL async_reset_n got %h exp 0", obs_n); end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_write_read();
    we = 1'b1; wr = 3'd3; din = 8'hA5; rd1 = 3'd0; rd2 = 3'd0;
    tick();
    we = 1'b0; rd1 = 3'd3; rd2 = 3'd3;
    #1;
    n_checks++;
    if (obs_b !== {8'hA5, 8'hA5, 4'b1100}) begin n_errors++; $display("FAIL wr_rd_same got %h exp %h", obs_b, {8'hA5, 8'hA5, 4'b1100}); end
    rd2 = 3'd4;
    #1;
    n_checks++;
    if (obs_n !== {8'hA5, 8'h00, 4'b1000}) begin n_errors++; $display("FAIL wr_rd_empty got %h exp %h", obs_n, {8'hA5, 8'h00, 4'b1000}); end
  endtask

  task automatic test_bypass();
    we = 1'b1; wr = 3'd5; din = 8'h3C; rd1 = 3'd5; rd2 = 3'd3;
    #1;
    n_checks++;
    if (obs_b !== {8'h3C, 8'hA5, 4'b1100}) begin n_errors++; $display("FAIL bypass_on got %h exp %h", obs_b, {8'h3C, 8'hA5, 4'b1100}); end
    n_checks++;
    if (obs_n !== {8'h00, 8'hA5, 4'b0100}) begin n_errors++; $display("FAIL bypass_off_pre got %h exp %h", obs_n, {8'h00, 8'hA5, 4'b0100}); end
    tick();
    we = 1'b0;
    #1;
    n_checks++;
    if (obs_n !== {8'h3C, 8'hA5, 4'b1100}) begin n_errors++; $display("FAIL bypass_off_post got %h exp %h", obs_n, {8'h3C, 8'hA5, 4'b1100}); end
  endtask

  task automatic test_clear();
    int cnt = 0;
    fill_all();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int c = 0; c < 20; c++) begin
      rd1 = AW'(c - 1); rd2 = AW'(c);
      #1;
      n_checks++;
      if (obs_b !== exp_vec(1'b1)) begin n_errors++; $display("FAIL clear_prog c%0d got %h exp %h", c, obs_b, exp_vec(1'b1)); end
      if (!b_if.busy) break;
      cnt++;
      tick();
    end
    n_checks++;
    if (cnt != D) begin n_errors++; $display("FAIL clear_busy_len got %0d exp %0d", cnt, D); end
  endtask

  task automatic test_drop();
    int guard = 0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    we = 1'b1; wr = 3'd2; din = 8'h11;
    tick();
    we = 1'b0;
    #1;
    n_checks++;
    if (b_if.wr_drop !== 1'b1) begin n_errors++; $display("FAIL drop_pulse got %b exp 1", b_if.wr_drop); end
    tick();
    n_checks++;
    if (b_if.wr_drop !== 1'b0) begin n_errors++; $display("FAIL drop_end got %b exp 0", b_if.wr_drop); end
    we = 1'b1;
    tick(); tick();
    we = 1'b0;
    #1;
    n_checks++;
    if (obs_n !== exp_vec(1'b0) || !m_drop) begin n_errors++; $display("FAIL drop_b2b got %h exp %h", obs_n, exp_vec(1'b0)); end
    while (b_if.busy && guard < 20) begin tick(); guard++; end
    n_checks++;
    if (b_if.busy) begin n_errors++; $display("FAIL drop_wait_idle got busy=1 exp 0"); end
    rd1 = 3'd2;
    #1;
    n_checks++;
    if ({b_if.data_out1, b_if.valid_out1} !== {8'h00, 1'b0}) begin n_errors++; $display("FAIL drop_entry2 got %h/%b exp 00/0", b_if.data_out1, b_if.valid_out1); end
    we = 1'b1; wr = 3'd2; din = 8'h11;
    tick();
    we = 1'b0;
    #1;
    n_checks++;
    if ({n_if.data_out1, n_if.valid_out1} !== {8'h11, 1'b1}) begin n_errors++; $display("FAIL drop_retry got %h/%b exp 11/1", n_if.data_out1, n_if.valid_out1); end
  endtask

  task automatic test_clear_held();
    int cnt = 0;
    fill_all();
    clr = 1'b1;
    tick();
    for (int c = 0; c < D; c++) begin
      rd1 = AW'($urandom); rd2 = AW'(c);
      #1;
      n_checks++;
      if (obs_b !== exp_vec(1'b1)) begin n_errors++; $display("FAIL held_prog c%0d got %h exp %h", c, obs_b, exp_vec(1'b1)); end
      if (b_if.busy) cnt++;
      tick();
    end
    clr = 1'b0;
    #1;
    n_checks++;
    if (b_if.busy !== 1'b0 || cnt != D) begin n_errors++; $display("FAIL held_len got busy=%b cnt=%0d exp 0/%0d", b_if.busy, cnt, D); end
    tick();
    n_checks++;
    if (b_if.busy !== 1'b0) begin n_errors++; $display("FAIL held_restart got busy=%b exp 0", b_if.busy); end
  endtask

  task automatic test_reset_mid_clear();
    fill_all();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (D / 2) tick();
    #2 reset = 1'b0;
    model_reset();
    #1;
    for (int a = 0; a < D; a++) begin
      rd1 = AW'(a); rd2 = AW'(a);
      #1;
      n_checks++;
      if (obs_b !== '0) begin n_errors++; $display("FAIL midclr_reset addr %0d got %h exp 0", a, obs_b); end
    end
    @(negedge clk) reset = 1'b1;
    tick();
    n_checks++;
    if (obs_n !== '0) begin n_errors++; $display("FAIL midclr_after got %h exp 0", obs_n); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      din = W'($urandom); wr = AW'($urandom); rd1 = AW'($urandom); rd2 = AW'($urandom);
      we = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 19) == 0);
      if (i % 5 == 0) rd1 = wr;
      #1;
      n_checks++;
      if (obs_b !== exp_vec(1'b1)) begin n_errors++; $display("FAIL rand_b i%0d got %h exp %h", i, obs_b, exp_vec(1'b1)); end
      n_checks++;
      if (obs_n !== exp_vec(1'b0)) begin n_errors++; $display("FAIL rand_n i%0d got %h exp %h", i, obs_n, exp_vec(1'b0)); end
      tick();
    end
    we = 1'b0; clr = 1'b0;
  endtask

  initial begin
    test_reset();
    tick();
    test_write_read();
    test_bypass();
    test_clear();
    test_drop();
    test_clear_held();
    test_reset_mid_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/reg_file_param.md
# reg_file_param

Parametrised multi-entry register file that succeeds the fixed 4x4 register file in the ALU datapath: WIDTH-bit entries, DEPTH entries, one write port, two asynchronous read ports. Adds per-entry valid bits, optional write-to-read bypass, and a sequential bulk-clear engine with busy and dropped-write indication. Sits between the ALU result bus (write side) and the ALU operand inputs (read side).

## Interface
- WIDTH, 4, bits per entry (>=1)
- DEPTH, 4, number of entries (power of two, >=2); AW = clog2(DEPTH) is derived, not overridable
- BYPASS, 1, 1 = same-cycle write data forwarded to a matching read port; 0 = no forwarding

- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately when low
- data_in  in  WIDTH  write data
- wr  in  AW  write address
- write_enable  in  1  write request, sampled at the rising edge
- rd1, rd2  in  AW  read addresses
- clear_req  in  1  bulk-clear request, sampled at the rising edge
- data_out1, data_out2  out  WIDTH  read data (combinational from state and inputs)
- valid_out1, valid_out2  out  1  entry written since last reset/clear
- busy  out  1  registered; high while the clear engine runs
- wr_drop  out  1  registered; one-cycle pulse for a write rejected during busy

## Operation
- Storage: DEPTH x WIDTH data flops plus DEPTH valid flops.
- Write accept: rising edge with write_enable=1 and busy=0 -> mem[wr] <= data_in, valid[wr] <= 1.
- Write reject: rising edge with write_enable=1 and busy=1 -> no state change, wr_drop=1 for the following cycle.
- Read: data_outN = mem[rdN], valid_outN = valid[rdN], with no clock involved.
- Bypass (BYPASS=1): if write_enable=1, busy=0 and wr==rdN, then data_outN = data_in and valid_outN = 1. Bypass is never active while busy=1.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR: at a rising edge with clear_req=1. The clear pointer ptr is set to 0 and busy goes high.
  - In CLEAR, on each edge: mem[ptr] <= 0, valid[ptr] <= 0, ptr <= ptr+1.
  - CLEAR -> IDLE: on the edge that clears entry DEPTH-1. busy goes low and ptr wraps to 0.
  - clear_req while in CLEAR is ignored; no restart and no queuing.
- Simultaneous clear_req and write in IDLE: the write is accepted because busy=0 at that edge. The entry is then erased by the clear pass.
- Reads during CLEAR return current contents. Entries not yet cleared keep their old data and valid.

## Timing
- Reset values: all mem=0, all valid=0, state=IDLE, ptr=0, busy=0, wr_drop=0. As a result, data_out1/2=0 and valid_out1/2=0.
- Reset asserted mid-clear aborts the pass immediately. Every entry is still zero because reset clears everything.
- Write-to-read latency: 0 cycles with BYPASS=1. With BYPASS=0, 1 cycle (the value is visible after the edge).
- Clear: busy is high for exactly DEPTH cycles, starting the cycle after the clear_req edge. A write is first accepted on the edge at which busy is seen low again.
- wr_drop is high for exactly one cycle per rejected edge. Back-to-back rejects keep it high continuously.

## Structure
- Shared package rf_pkg holds:
  - FSM state encoding: RF_IDLE=1'b0, RF_CLEAR=1'b1.
  - Default WIDTH and DEPTH constants.
- One sub-module, rf_read_port: DEPTH:1 mux with bypass compare and valid select, instantiated twice (successor of the 4:1 read mux).
- Write decode, storage, and the clear FSM stay in the top level.

## Test plan
- Reset, then read all addresses -> every data_out=0 and valid_out=0. Pull reset low mid-cycle -> outputs go to 0 without waiting for a clock edge.
- WIDTH=8, DEPTH=8: write 0xA5 to entry 3, then read rd1=3 and rd2=3 -> both return 0xA5 with valid=1. Read rd2=4 -> 0x00 with valid=0.
- BYPASS=1: write_enable=1, wr=5, data_in=0x3C, rd1=5 in the same cycle -> data_out1=0x3C and valid_out1=1 before the edge. With BYPASS=0 -> old value before the edge, 0x3C after it.
- Fill all 8 entries, pulse clear_req -> busy high for 8 cycles; entries read 0 and valid 0 progressively from address 0 to 7; busy low on the 9th cycle.
- Write to entry 2 with 0x11 during busy -> wr_drop pulses for one cycle; entry 2 stays 0 after the clear. The same write issued after busy falls -> accepted.
- Clear_req held high through a whole pass -> no restart; a new pass starts only on a clear_req edge in IDLE. Reset asserted at the midpoint of a pass -> busy=0 and all entries 0 and invalid.
